// File: rtl/urv_shifter_serial.sv
// ---------------------------------------------------------------------------
// urv_shifter_serial
//
// Multi-cycle SLL/SRL/SRA unit for the small-footprint uRV core. It replaces
// the 32-bit barrel shifter with a shifter that moves the operand by at most
// g_step bit positions per clock. The pipeline is held off with busy_o while
// the operation runs.
//
// Parameters:
//   g_step            maximum shift per clock (1, 2, 4 or 8)
//
// Ports:
//   clk_i             core clock, rising edge
//   rst_n_i           asynchronous active-low reset
//   x_stall_i         pipeline stall: blocks acceptance, holds result in DONE
//   kill_i            synchronous flush, aborts any operation
//   d_valid_i         shift operation presented by decode
//   d_rs1_i           32-bit operand
//   d_shamt_i         shift amount 0..31
//   d_fun_i           funct3 (3'b001 = left, anything else = right)
//   d_shifter_sign_i  arithmetic qualifier, honoured only for funct3 3'b101
//   busy_o            high whenever the unit is not idle
//   w_valid_o         result on w_rd_o is valid
//   w_rd_o            shift result (zero unless valid)
// ---------------------------------------------------------------------------
module urv_shifter_serial #(
  parameter int g_step = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        kill_i,
  input  logic        d_valid_i,
  input  logic [31:0] d_rs1_i,
  input  logic [4:0]  d_shamt_i,
  input  logic [2:0]  d_fun_i,
  input  logic        d_shifter_sign_i,
  output logic        busy_o,
  output logic        w_valid_o,
  output logic [31:0] w_rd_o
);

  localparam logic [2:0] FUNC_SL = 3'b001;
  localparam logic [2:0] FUNC_SR = 3'b101;
  localparam logic [4:0] STEP    = 5'(g_step);

  // Only power-of-two steps up to 8 are supported.
  generate
    if (!(g_step == 1 || g_step == 2 || g_step == 4 || g_step == 8)) begin : g_bad_step
      $error("urv_shifter_serial: g_step must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  remain_q, remain_d;
  logic        dir_left_q, dir_left_d;
  logic        fill_q, fill_d;

  logic        accept;
  logic [4:0]  step_k;
  logic [4:0]  remain_next;
  logic [31:0] shifted;
  logic [63:0] wide_fill;
  logic [63:0] wide_shr;

  assign accept = (state_q == ST_IDLE) && d_valid_i && !x_stall_i && !kill_i;

  // One iteration of the shifter. Only the shift amounts 1..g_step are
  // decoded so the mux stays g_step wide instead of a full barrel shifter.
  // Right shifts pull in copies of fill from the upper half of wide_fill.
  always_comb begin
    step_k      = (remain_q < STEP) ? remain_q : STEP;
    remain_next = remain_q - step_k;
    wide_fill   = {{32{fill_q}}, acc_q};
    wide_shr    = wide_fill;
    shifted     = acc_q;
    for (int i = 1; i <= g_step; i++) begin
      if (step_k == 5'(i)) begin
        if (dir_left_q) begin
          shifted = acc_q << i;
        end else begin
          wide_shr = wide_fill >> i;
          shifted  = wide_shr[31:0];
        end
      end
    end
  end

  // State register and datapath flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      remain_q   <= '0;
      dir_left_q <= 1'b0;
      fill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      remain_q   <= remain_d;
      dir_left_q <= dir_left_d;
      fill_q     <= fill_d;
    end
  end

  // Next-state logic. A flush wins over everything, including acceptance.
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept) state_d = (d_shamt_i == 5'd0) ? ST_DONE : ST_SHIFT;
        ST_SHIFT: if (remain_next == 5'd0) state_d = ST_DONE;
        ST_DONE:  if (!x_stall_i) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath updates: load on acceptance, iterate while shifting, otherwise
  // hold (which keeps the result stable while DONE is stalled).
  always_comb begin
    acc_d      = acc_q;
    remain_d   = remain_q;
    dir_left_d = dir_left_q;
    fill_d     = fill_q;
    if (accept) begin
      acc_d      = d_rs1_i;
      remain_d   = d_shamt_i;
      dir_left_d = (d_fun_i == FUNC_SL);
      fill_d     = (d_fun_i == FUNC_SR) && d_shifter_sign_i && d_rs1_i[31];
    end else if (state_q == ST_SHIFT && !kill_i) begin
      acc_d    = shifted;
      remain_d = remain_next;
    end
  end

  // Outputs decode only the state flops; the result is gated so stale
  // accumulator contents never leak onto the writeback bus.
  always_comb begin
    busy_o    = (state_q != ST_IDLE);
    w_valid_o = (state_q == ST_DONE);
    w_rd_o    = (state_q == ST_DONE) ? acc_q : 32'd0;
  end

endmodule
